inlier_stream_sender: RTL and testbench
=======================================

# inlier_stream_sender

Initiator side of the inlier-checker word protocol. On `start`, serializes one RANSAC line model (deltaX, deltaY, beta, threshold) and a list of 8-bit (x,y) points read from a point RAM into the 32-bit word stream consumed by the inlier checker. The stream ends with the all-ones sentinel. Sits between the point buffer and the checker, replacing the software word loop. It also counts the inlier flags returned per point.

## Interface
- `ADDR_W`, 10: point RAM address width; max points = 2^ADDR_W.
- `RESULT_LAT`, 3: cycles from a point word's `enable` cycle to its valid `inlier_in`; must be ≥1.
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `delta_x` in 9: signed model deltaX, latched on start.
- `delta_y` in 9: signed model deltaY, latched on start.
- `beta` in 17: signed model beta, latched on start.
- `threshold` in 32: signed threshold, latched on start.
- `num_points` in ADDR_W+1: point count, latched on start; 0 legal.
- `mem_addr` out ADDR_W: point RAM read address.
- `mem_rd_en` out 1: RAM read strobe.
- `mem_rdata` in 16: {y[7:0], x[7:0]}, valid the cycle after the address is sampled.
- `data_out` out 32: protocol word, registered.
- `enable` out 1: `data_out` valid this cycle; one word per high cycle.
- `inlier_in` in 1: checker result bit.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse at end of frame.
- `inlier_count` out ADDR_W+1: inliers of last frame; holds until next start.

## Operation
- FSM states: IDLE, DX, DY, BETA, THR, PTS, SENT, DRAIN.
  - IDLE + start goes to DX.
  - DX goes to DY, then BETA, then THR.
  - THR goes to PTS if N>0, else to SENT.
  - PTS goes to SENT after the N-th point.
  - SENT goes to DRAIN.
  - DRAIN goes to IDLE after RESULT_LAT cycles, with `done` pulsing on that transition.
- Word encoding:
  - DX: sign-extended `delta_x`.
  - DY: sign-extended `delta_y`.
  - BETA: sign-extended `beta`.
  - THR: `threshold`.
  - Point: {16'h0000, y, x}.
  - SENT: 32'hFFFFFFFF.
- Outside word cycles, `data_out` holds its last value and `enable`=0.
- Point index i runs 0..N-1 as an ADDR_W+1 counter. `mem_addr` = i[ADDR_W-1:0]. When N = 2^ADDR_W, the index ends at 2^ADDR_W and does not wrap before SENT.
- Result tracking: a RESULT_LAT-deep tag shift register is loaded with 1 on each point word and 0 otherwise. When the tag leaves the register, `inlier_in` is added to the count.
- The sentinel's result is never counted. The count saturates at 2^ADDR_W (unreachable by construction).
- `start` while busy is ignored. Input changes after start have no effect on the frame.
- Reset values: `enable`=0, `data_out`=0, `mem_rd_en`=0, `mem_addr`=0, `busy`=0, `done`=0, `inlier_count`=0, FSM in IDLE, tags cleared.
- Reset mid-frame aborts immediately with no sentinel. The checker must be reset with the sender.

## Timing
- `start` is sampled high at edge k.
- Header words carry `enable`=1 in cycles k+1 (DX), k+2 (DY), k+3 (BETA) and k+4 (THR).
- Point i is driven in cycle k+5+i. Its RAM read is issued with `mem_rd_en`=1 and `mem_addr`=i in cycle k+3+i.
- Sentinel is driven in cycle k+5+N.
- `done` pulses in cycle k+6+N+RESULT_LAT. `inlier_count` is final in that same cycle.
- Frame length is N+5 words, back-to-back with no gaps.
- Next `start` is accepted in the cycle after `done`.

## Configuration
- `INLIER_COUNT_EN` defined: tag register and counter are built; `inlier_count` and DRAIN behave as specified.
- `INLIER_COUNT_EN` undefined:
  - `inlier_in` is ignored and `inlier_count` is tied to 0.
  - DRAIN is removed: SENT goes directly to IDLE, and `done` pulses in cycle k+6+N.

## Structure
- Shared package `ransac_pkg`:
  - FSM state encoding.
  - SENTINEL = 32'hFFFFFFFF.
  - Header word order constants.
  - Point word packing function (shared with the checker side).
- One sub-module, `inlier_result_counter`: tag shift register plus counter, instantiated only under `INLIER_COUNT_EN`.

## Test plan
- Basic frame: dx=-3, dy=5, beta=-100, thr=400, N=3 with RAM {0x0102, 0x0304, 0x0506}.
  - Words, one per cycle: 0xFFFFFFFD, 0x00000005, 0xFFFFFF9C, 0x00000190, 0x0102, 0x0304, 0x0506, 0xFFFFFFFF.
  - `done` pulses at k+9+RESULT_LAT.
- N=0: five words (4 header + sentinel); `inlier_count`=0; `done` at k+6+RESULT_LAT.
- Counting: N=4, `inlier_in` model returns 1,0,1,1 at the tagged cycles; also returns 1 for the sentinel slot. `inlier_count`=3.
- N=2^ADDR_W with ADDR_W=4 (16 points): `mem_addr` 0..15 with no wrap; exactly 16 point words before the sentinel.
- `start` pulsed during PTS: no effect on the frame. `start` in the cycle after `done`: new frame begins at the next edge.
- `reset_n` low during point 2 of 5: all outputs go to reset values asynchronously; no sentinel is emitted. After release, a new `start` produces a clean frame.

Source files
------------

// File: rtl/ransac_pkg.sv
// ============================================================================
// Module   : ransac_pkg
// Brief    : Types and constants shared by the inlier-checker word protocol.
//            Holds the sender FSM encoding, the stream sentinel, the header
//            word order and the point word packing function.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ransac_pkg;

  // One state per word type on the stream, plus idle and result drain
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DX    = 3'd1,
    ST_DY    = 3'd2,
    ST_BETA  = 3'd3,
    ST_THR   = 3'd4,
    ST_PTS   = 3'd5,
    ST_SENT  = 3'd6,
    ST_DRAIN = 3'd7
  } state_t;

  // End-of-frame marker; the checker never sees this value as a point
  localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;

  // Header word order on the stream
  localparam logic [1:0] HDR_DX   = 2'd0;
  localparam logic [1:0] HDR_DY   = 2'd1;
  localparam logic [1:0] HDR_BETA = 2'd2;
  localparam logic [1:0] HDR_THR  = 2'd3;

  // Builds one header word; signed model fields are sign-extended to 32 bits
  function automatic logic [31:0] header_word(
    input logic [1:0]  sel,
    input logic [8:0]  dx,
    input logic [8:0]  dy,
    input logic [16:0] beta,
    input logic [31:0] thr
  );
    logic [31:0] w_word;
    case (sel)
      HDR_DX:   w_word = {{23{dx[8]}}, dx};
      HDR_DY:   w_word = {{23{dy[8]}}, dy};
      HDR_BETA: w_word = {{15{beta[16]}}, beta};
      default:  w_word = thr;
    endcase
    return w_word;
  endfunction

  // Point word layout shared with the checker: {16'h0000, y, x}
  function automatic logic [31:0] pack_point(input logic [7:0] x, input logic [7:0] y);
    return {16'h0000, y, x};
  endfunction

endpackage

`default_nettype wire

// File: rtl/inlier_stream_sender_if.sv
// ============================================================================
// Module   : inlier_stream_sender_if
// Brief    : Point RAM read port plus checker word stream of the sender.
//            master = sender side, slave = RAM/checker side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inlier_stream_sender_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [15:0]       mem_rdata;
  logic [31:0]       data_out;
  logic              enable;
  logic              inlier_in;

  modport master (
    output mem_addr, mem_rd_en, data_out, enable,
    input  mem_rdata, inlier_in
  );

  modport slave (
    input  mem_addr, mem_rd_en, data_out, enable,
    output mem_rdata, inlier_in
  );
endinterface

`default_nettype wire

// File: rtl/inlier_result_counter.sv
// ============================================================================
// Module   : inlier_result_counter
// Brief    : Tags each stream cycle that carried a point word and, when the
//            tag comes out RESULT_LAT cycles later, adds the checker's result
//            bit to a saturating inlier count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inlier_result_counter #(
  parameter int ADDR_W     = 10,
  parameter int RESULT_LAT = 3
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              i_clear,
  input  wire logic              i_tag,
  input  wire logic              i_inlier,
  output logic      [ADDR_W:0]   o_count
);

  localparam logic [ADDR_W:0] c_one = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] c_max = {1'b1, {ADDR_W{1'b0}}};

  logic [RESULT_LAT-1:0] r_tag;
  logic [ADDR_W:0]       r_count;
  logic                  w_exit;

  assign w_exit  = r_tag[RESULT_LAT-1];
  assign o_count = r_count;

  // Delay line aligning each point tag with the cycle its result is valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= i_tag;
      for (int j = 1; j < RESULT_LAT; j++) begin
        r_tag[j] <= r_tag[j-1];
      end
    end
  end

  // Count tagged inliers; cleared when a new frame is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (w_exit && i_inlier && (r_count != c_max)) begin
      r_count <= r_count + c_one;
    end
  end

endmodule

`default_nettype wire

// File: rtl/inlier_stream_sender.sv
// ============================================================================
// Module   : inlier_stream_sender
// Brief    : Serialises one RANSAC line model and a list of points read from
//            the point RAM into the inlier-checker word stream, terminated by
//            the all-ones sentinel. Optional inlier counting is built when the
//            INLIER_COUNT_EN macro is defined; otherwise the result drain is
//            removed and inlier_count reads 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inlier_stream_sender
  import ransac_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int RESULT_LAT = 3
) (
  input  wire logic                clk,
  input  wire logic                reset_n,
  input  wire logic                start,
  input  wire logic signed [8:0]   delta_x,
  input  wire logic signed [8:0]   delta_y,
  input  wire logic signed [16:0]  beta,
  input  wire logic signed [31:0]  threshold,
  input  wire logic [ADDR_W:0]     num_points,
  inlier_stream_sender_if.master   bus,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W:0]          inlier_count
);

  localparam logic [ADDR_W:0] c_one = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next;
  logic signed [8:0]   r_dy;
  logic signed [16:0]  r_beta;
  logic signed [31:0]  r_thr;
  logic [ADDR_W:0]     r_n;
  logic [ADDR_W:0]     r_rd_idx;   // next point to read from RAM
  logic [ADDR_W:0]     r_pt_idx;   // point currently on the stream
  logic [31:0]         r_data;
  logic                r_en;
  logic                r_done;
  logic [31:0]         w_data_nxt;
  logic                w_en_nxt;
  logic                w_rd_en;
  logic                w_start_ok;
  logic                w_last_pt;
  logic                w_drain_end;

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_last_pt  = ((r_pt_idx + c_one) == r_n);

`ifdef INLIER_COUNT_EN
  localparam int              c_drain_w    = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
  localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(RESULT_LAT - 1);
  localparam logic [c_drain_w-1:0] c_drain_one  = c_drain_w'(1);

  logic [c_drain_w-1:0] r_drain_cnt;

  // Hold off done until the last point's result has been counted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drain_cnt <= '0;
    end else if (r_state == ST_DRAIN) begin
      r_drain_cnt <= r_drain_cnt + c_drain_one;
    end else begin
      r_drain_cnt <= '0;
    end
  end

  assign w_drain_end = (r_drain_cnt == c_drain_last);

  inlier_result_counter #(
    .ADDR_W     (ADDR_W),
    .RESULT_LAT (RESULT_LAT)
  ) u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_start_ok),
    .i_tag    (r_state == ST_PTS),
    .i_inlier (bus.inlier_in),
    .o_count  (inlier_count)
  );
`else
  localparam int c_unused_lat = RESULT_LAT;
  logic w_unused_inlier;

  assign w_unused_inlier = bus.inlier_in;
  assign w_drain_end     = 1'b1;
  assign inlier_count    = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: the state names the word type on the stream in that cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_DX;
      ST_DX:    w_next = ST_DY;
      ST_DY:    w_next = ST_BETA;
      ST_BETA:  w_next = ST_THR;
      ST_THR:   w_next = (r_n != '0) ? ST_PTS : ST_SENT;
      ST_PTS:   if (w_last_pt) w_next = ST_SENT;
`ifdef INLIER_COUNT_EN
      ST_SENT:  w_next = ST_DRAIN;
`else
      ST_SENT:  w_next = ST_IDLE;
`endif
      ST_DRAIN: if (w_drain_end) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs: next word from the state being entered; RAM reads run two
  // cycles ahead of the point words so read data lands as the word is built
  always_comb begin
    w_data_nxt = r_data;
    w_en_nxt   = 1'b0;
    w_rd_en    = ((r_state == ST_BETA) || (r_state == ST_THR) || (r_state == ST_PTS))
                 && (r_rd_idx < r_n);
    case (w_next)
      ST_DX: begin
        w_data_nxt = header_word(HDR_DX, delta_x, r_dy, r_beta, r_thr);
        w_en_nxt   = 1'b1;
      end
      ST_DY: begin
        w_data_nxt = header_word(HDR_DY, delta_x, r_dy, r_beta, r_thr);
        w_en_nxt   = 1'b1;
      end
      ST_BETA: begin
        w_data_nxt = header_word(HDR_BETA, delta_x, r_dy, r_beta, r_thr);
        w_en_nxt   = 1'b1;
      end
      ST_THR: begin
        w_data_nxt = header_word(HDR_THR, delta_x, r_dy, r_beta, r_thr);
        w_en_nxt   = 1'b1;
      end
      ST_PTS: begin
        w_data_nxt = pack_point(bus.mem_rdata[7:0], bus.mem_rdata[15:8]);
        w_en_nxt   = 1'b1;
      end
      ST_SENT: begin
        w_data_nxt = SENTINEL;
        w_en_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  // Word register, frame parameters and point indices
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= '0;
      r_en     <= 1'b0;
      r_done   <= 1'b0;
      r_dy     <= '0;
      r_beta   <= '0;
      r_thr    <= '0;
      r_n      <= '0;
      r_rd_idx <= '0;
      r_pt_idx <= '0;
    end else begin
      r_data <= w_data_nxt;
      r_en   <= w_en_nxt;
      r_done <= (r_state != ST_IDLE) && (w_next == ST_IDLE);
      if (w_start_ok) begin
        r_dy     <= delta_y;
        r_beta   <= beta;
        r_thr    <= threshold;
        r_n      <= num_points;
        r_rd_idx <= '0;
        r_pt_idx <= '0;
      end else begin
        if (w_rd_en) begin
          r_rd_idx <= r_rd_idx + c_one;
        end
        if (r_state == ST_PTS) begin
          r_pt_idx <= r_pt_idx + c_one;
        end
      end
    end
  end

  assign bus.data_out  = r_data;
  assign bus.enable    = r_en;
  assign bus.mem_rd_en = w_rd_en;
  assign bus.mem_addr  = r_rd_idx[ADDR_W-1:0];
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_inlier_stream_sender.sv
// ============================================================================
// Module   : tb_inlier_stream_sender
// Brief    : Directed self-checking bench for inlier_stream_sender with a
//            point RAM model, a checker model returning word bit 0 as the
//            result, and scoreboards for words, RAM reads and done.
//            Expectations follow INLIER_COUNT_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inlier_stream_sender;
  import ransac_pkg::*;

  localparam int ADDR_W     = 4;
  localparam int RESULT_LAT = 3;
`ifdef INLIER_COUNT_EN
  localparam int LAT_EFF = RESULT_LAT;
  localparam bit CNT_EN  = 1'b1;
`else
  localparam int LAT_EFF = 0;
  localparam bit CNT_EN  = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [8:0]        delta_x = '0;
  logic [8:0]        delta_y = '0;
  logic [16:0]       beta = '0;
  logic [31:0]       threshold = '0;
  logic [ADDR_W:0]   num_points = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   inlier_count;

  inlier_stream_sender_if #(.ADDR_W(ADDR_W)) bus ();

  inlier_stream_sender #(
    .ADDR_W     (ADDR_W),
    .RESULT_LAT (RESULT_LAT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .delta_x      (delta_x),
    .delta_y      (delta_y),
    .beta         (beta),
    .threshold    (threshold),
    .num_points   (num_points),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .inlier_count (inlier_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Point RAM: one-cycle read latency
  logic [15:0] ram [0:15];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];

  // Checker model: result for every word is its bit 0, RESULT_LAT cycles later
  logic [RESULT_LAT-1:0] pipe;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pipe <= '0;
    else          pipe <= {pipe[RESULT_LAT-2:0], bus.enable & bus.data_out[0]};
  end
  assign bus.inlier_in = pipe[RESULT_LAT-1];

  typedef struct {
    logic [31:0] v;
    int          c;
  } exp_t;

  exp_t q_word[$];
  exp_t q_read[$];
  exp_t q_done[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: compare every word, read and done pulse as it appears
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n) begin
      if (bus.enable) begin
        if (q_word.size() == 0) check("unexpected_word", bus.data_out, 32'h0);
        else begin
          e = q_word.pop_front();
          check("word", bus.data_out, e.v);
          check("word_cycle", 32'(cyc), 32'(e.c));
        end
      end
      if (bus.mem_rd_en) begin
        if (q_read.size() == 0) check("unexpected_read", {28'h0, bus.mem_addr}, 32'h0);
        else begin
          e = q_read.pop_front();
          check("read_addr", {28'h0, bus.mem_addr}, e.v);
          check("read_cycle", 32'(cyc), 32'(e.c));
        end
      end
      if (done) begin
        if (q_done.size() == 0) check("unexpected_done", {31'h0, done}, 32'h0);
        else begin
          e = q_done.pop_front();
          check("inlier_count", {27'h0, inlier_count}, e.v);
          check("done_cycle", 32'(cyc), 32'(e.c));
        end
      end
    end
  end

  // Call right after a rising edge; start is sampled at the following edge
  task automatic start_frame(input int dx, input int dy, input int b, input int thr, input int n);
    int e_cyc;
    int cnt;
    #1;
    delta_x    = dx[8:0];
    delta_y    = dy[8:0];
    beta       = b[16:0];
    threshold  = thr;
    num_points = n[ADDR_W:0];
    start      = 1'b1;
    e_cyc      = cyc + 1;
    cnt        = 0;
    q_word.push_back('{32'(dx),  e_cyc});
    q_word.push_back('{32'(dy),  e_cyc + 1});
    q_word.push_back('{32'(b),   e_cyc + 2});
    q_word.push_back('{32'(thr), e_cyc + 3});
    for (int i = 0; i < n; i++) begin
      q_word.push_back('{{16'h0000, ram[i]}, e_cyc + 4 + i});
      q_read.push_back('{32'(i), e_cyc + 2 + i});
      if (CNT_EN) cnt += int'(ram[i][0]);
    end
    q_word.push_back('{32'hFFFF_FFFF, e_cyc + 4 + n});
    q_done.push_back('{32'(cnt), e_cyc + 5 + n + LAT_EFF});
    @(posedge clk);
    #1;
    start      = 1'b0;
    delta_x    = 9'($urandom);
    delta_y    = 9'($urandom);
    beta       = 17'($urandom);
    threshold  = $urandom;
    num_points = 5'($urandom);
  endtask

  // Returns on the rising edge right after the done cycle
  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (q_done.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    check("done_timeout_pending", 32'(q_done.size()), 32'h0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_enable"},       {31'h0, bus.enable},    32'h0);
    check({pfx, "_data_out"},     bus.data_out,           32'h0);
    check({pfx, "_mem_rd_en"},    {31'h0, bus.mem_rd_en}, 32'h0);
    check({pfx, "_mem_addr"},     {28'h0, bus.mem_addr},  32'h0);
    check({pfx, "_busy"},         {31'h0, busy},          32'h0);
    check({pfx, "_done"},         {31'h0, done},          32'h0);
    check({pfx, "_inlier_count"}, {27'h0, inlier_count},  32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 16'h0000;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk);

    // Basic frame
    ram[0] = 16'h0102; ram[1] = 16'h0304; ram[2] = 16'h0506;
    start_frame(-3, 5, -100, 400, 3);
    wait_done(40);

    // Empty frame; odd header values make every non-point result a 1
    start_frame(11, -1, 3, -5, 0);
    wait_done(40);

    // Counting: x LSBs 1,0,1,1; header and sentinel results also 1
    ram[0] = 16'h1111; ram[1] = 16'h2222; ram[2] = 16'h3333; ram[3] = 16'h4445;
    start_frame(7, -9, 1, -1, 4);
    wait_done(40);

    // Full RAM, with a start pulse while points are streaming
    for (int i = 0; i < 16; i++) ram[i] = {8'(3 * i + 1), 8'(i)};
    start_frame(-255, 255, -65536, 32'h7FFF_FFFF, 16);
    repeat (8) @(posedge clk);
    #1;
    start = 1'b1;
    check("busy_in_pts", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(60);

    // Start in the cycle after done
    ram[0] = 16'hA5C3; ram[1] = 16'h5A3C;
    start_frame(1, 2, 3, 4, 2);
    wait_done(40);

    // Reset while point 2 of 5 is on the stream
    for (int i = 0; i < 5; i++) ram[i] = {8'(i), 8'(2 * i + 1)};
    start_frame(-1, -1, -1, -1, 5);
    repeat (6) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    q_word.delete();
    q_read.delete();
    q_done.delete();
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    check("idle_after_abort", {31'h0, busy}, 32'h0);

    // Clean frame after the abort
    ram[0] = 16'h7F81;
    start_frame(5, 5, 5, 5, 1);
    wait_done(40);

    repeat (5) @(posedge clk);
    check("words_left", 32'(q_word.size()), 32'h0);
    check("reads_left", 32'(q_read.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
